// File: rtl/sram_sync_model.sv
// Synchronous SRAM model: byte-lane writes, RD_LAT-cycle pipelined read-first reads, and an
// optional screen-dump streaming engine compiled in only when SRAM_SYNC_MODEL_DUMP_EN is defined.
module sram_sync_model #(
    parameter int AW     = 18,
    parameter int DW     = 16,
    parameter int RD_LAT = 1,
    parameter int SCR_W  = 400,
    parameter int SCR_H  = 96,
    parameter int SCR_N  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,
    input  logic              WE,
    input  logic [DW/8-1:0]   BE,
    input  logic [AW-1:0]     ADDR,
    input  logic [DW-1:0]     WDATA,
    output logic [DW-1:0]     RDATA,
    output logic              RVALID,
    input  logic              DUMP_START,
    output logic              DUMP_BUSY,
    output logic              DUMP_VALID,
    input  logic              DUMP_READY,
    output logic [DW-1:0]     DUMP_DATA,
    output logic              DUMP_CH,
    output logic              DUMP_LAST
);
    localparam int NB = DW / 8;

    logic [DW-1:0]             mem_q [2**AW];
    logic [AW-1:0]             rd_addr_s;
    logic [DW-1:0]             rd_data_s;
    logic                      host_rd_s;
    logic [RD_LAT:1]           hv_q, hv_d;
    logic [RD_LAT:1][DW-1:0]   d_q, d_d;
    logic [RD_LAT:0]           hv_s;
    logic [RD_LAT:0][DW-1:0]   d_s;

    assign host_rd_s = CE & ~WE;
    assign rd_data_s = mem_q[rd_addr_s];

    // Byte-lane writes; the same-edge read above still sees the old word (read-first)
    always_ff @(posedge CLK) begin
        if (CE && WE) begin
            for (int b = 0; b < NB; b++) begin
                if (BE[b]) mem_q[ADDR][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    // Read pipeline shift; the last stage keeps the previous host word while no host read lands
    always_comb begin
        hv_s        = {hv_q, host_rd_s};
        d_s         = {d_q, rd_data_s};
        hv_d        = hv_s[RD_LAT-1:0];
        d_d         = d_s[RD_LAT-1:0];
        d_d[RD_LAT] = hv_s[RD_LAT-1] ? d_s[RD_LAT-1] : d_q[RD_LAT];
    end

    // Read pipeline registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            hv_q <= '0;
            d_q  <= '0;
        end else begin
            hv_q <= hv_d;
            d_q  <= d_d;
        end
    end

    assign RVALID = hv_s[RD_LAT];
    assign RDATA  = d_s[RD_LAT];

`ifdef SRAM_SYNC_MODEL_DUMP_EN
    localparam int PW = (SCR_N > 1) ? $clog2(SCR_N) : 1;
    localparam int FW = 17 + PW;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_NEXT} state_t;

    state_t          state_q, state_d;
    logic [8:0]      x_q, x_d;
    logic [6:0]      y_q, y_d;
    logic [PW-1:0]   page_q, page_d;
    logic            ch_q, ch_d;
    logic            start_prev_q;
    logic            start_rise_s, dump_issue_s, last_s;
    logic [RD_LAT:1] dv_q, dv_d;
    logic [RD_LAT:0] dv_s;
    logic [DW-1:0]   dump_data_q, dump_data_d;
    logic            busy_q, busy_d, valid_q, valid_d, last_q, last_d;
    logic [FW-1:0]   dump_full_s;

    assign start_rise_s = DUMP_START & ~start_prev_q;
    assign dump_full_s  = {page_q, ch_q, y_q, x_q};
    assign rd_addr_s    = CE ? ADDR : AW'(dump_full_s);
    assign last_s       = ch_q & (32'(x_q) == 32'(SCR_W - 1)) & (32'(y_q) == 32'(SCR_H - 1))
                          & (32'(page_q) == 32'(SCR_N - 1));

    // Dump FSM: host CE defers the ISSUE read; ch toggles fastest, then x, y, page
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        page_d       = page_q;
        ch_d         = ch_q;
        dump_issue_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_rise_s) state_d = S_ISSUE;
                else              state_d = S_IDLE;
            end
            S_ISSUE: begin
                if (!CE) begin
                    dump_issue_s = 1'b1;
                    state_d      = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (dv_s[RD_LAT]) state_d = S_OUT;
                else              state_d = S_WAIT;
            end
            S_OUT: begin
                if (DUMP_READY) state_d = S_NEXT;
                else            state_d = S_OUT;
            end
            S_NEXT: begin
                ch_d = ~ch_q;
                if (ch_q) begin
                    if (32'(x_q) == 32'(SCR_W - 1)) begin
                        x_d = 9'd0;
                        if (32'(y_q) == 32'(SCR_H - 1)) begin
                            y_d = 7'd0;
                            if (32'(page_q) == 32'(SCR_N - 1)) page_d = '0;
                            else                                page_d = page_q + PW'(1);
                        end else begin
                            y_d = y_q + 7'd1;
                        end
                    end else begin
                        x_d = x_q + 9'd1;
                    end
                end else begin
                    x_d = x_q;
                end
                if (last_s) state_d = S_IDLE;
                else        state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
        valid_d     = (state_d == S_OUT);
        last_d      = (state_d == S_OUT) & last_s;
        busy_d      = (state_d != S_IDLE);
        dv_s        = {dv_q, dump_issue_s};
        dv_d        = dv_s[RD_LAT-1:0];
        dump_data_d = dv_s[RD_LAT-1] ? d_s[RD_LAT-1] : dump_data_q;
    end

    // Dump state; start_prev resets high so a level held through reset is not an edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            x_q          <= 9'd0;
            y_q          <= 7'd0;
            page_q       <= '0;
            ch_q         <= 1'b0;
            start_prev_q <= 1'b1;
            dv_q         <= '0;
            dump_data_q  <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            page_q       <= page_d;
            ch_q         <= ch_d;
            start_prev_q <= DUMP_START;
            dv_q         <= dv_d;
            dump_data_q  <= dump_data_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
        end
    end

    assign DUMP_BUSY  = busy_q;
    assign DUMP_VALID = valid_q;
    assign DUMP_LAST  = last_q;
    assign DUMP_CH    = ch_q;
    assign DUMP_DATA  = dump_data_q;
`else
    logic unused_dump_s;

    assign rd_addr_s     = ADDR;
    assign unused_dump_s = DUMP_START ^ DUMP_READY;
    assign DUMP_BUSY     = 1'b0;
    assign DUMP_VALID    = 1'b0;
    assign DUMP_LAST     = 1'b0;
    assign DUMP_CH       = 1'b0;
    assign DUMP_DATA     = '0;
`endif
endmodule

// File: tb/tb_sram_sync_model.sv
// Directed bench for sram_sync_model (RD_LAT=3, 4x2x2 dump frame); dump scenarios run
// when SRAM_SYNC_MODEL_DUMP_EN is defined, otherwise the dump outputs must stay tied low.
module tb_sram_sync_model;
    localparam int AW = 18, DW = 16, RD_LAT = 3, SW = 4, SH = 2, SN = 2;
    localparam int NBEATS = 2 * SW * SH * SN;
    localparam int NVEC = 26;

    logic clk = 1'b0;
    logic rst, ce, we, rvalid, dstart, dbusy, dvalid, dready, dch, dlast;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata, ddata;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_sync_model #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .SCR_W(SW), .SCR_H(SH), .SCR_N(SN)) dut (
        .CLK(clk), .RST(rst), .CE(ce), .WE(we), .BE(be), .ADDR(addr), .WDATA(wdata),
        .RDATA(rdata), .RVALID(rvalid), .DUMP_START(dstart), .DUMP_BUSY(dbusy),
        .DUMP_VALID(dvalid), .DUMP_READY(dready), .DUMP_DATA(ddata), .DUMP_CH(dch),
        .DUMP_LAST(dlast)
    );

    typedef struct {
        logic          ce;
        logic          we;
        logic [1:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          exp_v;
        logic [DW-1:0] exp_d;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic host(input logic c, input logic w, input logic [1:0] b,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        ce = c; we = w; be = b; addr = a; wdata = d;
    endtask

    function automatic logic [AW-1:0] beat_addr(input int b);
        int ch, x, y, pg;
        ch = b % 2;
        x  = (b / 2) % SW;
        y  = (b / (2 * SW)) % SH;
        pg = b / (2 * SW * SH);
        return AW'((pg << 17) | (ch << 16) | (y << 9) | x);
    endfunction

    // Runs the dump stream until stop_after beats are taken (and, for a full run, BUSY drops).
    task automatic collect(input bit stall, input bit hostrd, input int stop_after, output int nbeats);
        int cyc;
        int pend_due [$];
        logic [DW-1:0] pend_d [$];
        bit prev_stall, done, sel;
        logic [DW-1:0] held_d;
        logic held_ch;
        cyc = 0; nbeats = 0; prev_stall = 1'b0; done = 1'b0; sel = 1'b0;
        held_d = '0; held_ch = 1'b0;
        while (cyc < 3000) begin
            if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                chk("host_rvalid", rvalid, 1);
                chk("host_rdata", rdata, pend_d[0]);
                void'(pend_due.pop_front());
                void'(pend_d.pop_front());
            end else if (rvalid) begin
                chk("host_rvalid_spurious", rvalid, 0);
            end
            if (prev_stall) begin
                chk("stall_valid", dvalid, 1);
                chk("stall_data", ddata, held_d);
                chk("stall_ch", dch, held_ch);
            end
            dready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (dvalid && dready) begin
                chk($sformatf("beat%0d_data", nbeats), ddata, 16'hD000 | 16'(nbeats));
                chk($sformatf("beat%0d_ch", nbeats), dch, nbeats % 2);
                chk($sformatf("beat%0d_last", nbeats), dlast, (nbeats == NBEATS - 1) ? 1 : 0);
                nbeats++;
            end else if (!dvalid && dlast) begin
                chk("last_without_valid", dlast, 0);
            end
            prev_stall = dvalid && !dready;
            held_d = ddata;
            held_ch = dch;
            done = (nbeats >= stop_after);
            if (hostrd && !done && $urandom_range(0, 1) == 1) begin
                sel = ~sel;
                host(1'b1, 1'b0, 2'b00, sel ? 18'h00010 : 18'h00020, 16'h0000);
                pend_due.push_back(cyc + RD_LAT);
                pend_d.push_back(sel ? 16'hA5FF : 16'h9934);
            end else begin
                host(1'b0, 1'b0, 2'b00, 18'h0, 16'h0000);
            end
            tick;
            cyc++;
            if (done && pend_due.size() == 0 && (stop_after < NBEATS || !dbusy)) break;
        end
        chk("collect_bound", (cyc < 3000) ? 1 : 0, 1);
        chk("collect_beats", nbeats, stop_after);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{1'b1, 1'b1, 2'b11, 18'h10, 16'hA5C3, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 2'b01, 18'h10, 16'hFFFF, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 2'b00, 18'h10, 16'h0000, 1'b0, 16'h0000};
        vecs[3]  = '{1'b1, 1'b1, 2'b11, 18'h01, 16'h0001, 1'b0, 16'h0000};
        vecs[4]  = '{1'b1, 1'b1, 2'b11, 18'h02, 16'h0002, 1'b1, 16'hA5FF};
        vecs[5]  = '{1'b1, 1'b1, 2'b11, 18'h03, 16'h0003, 1'b0, 16'hA5FF};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 18'h01, 16'h0000, 1'b0, 16'hA5FF};
        vecs[7]  = '{1'b1, 1'b0, 2'b00, 18'h02, 16'h0000, 1'b0, 16'hA5FF};
        vecs[8]  = '{1'b1, 1'b0, 2'b00, 18'h03, 16'h0000, 1'b1, 16'h0001};
        vecs[9]  = '{1'b1, 1'b1, 2'b11, 18'h20, 16'h0BAD, 1'b1, 16'h0002};
        vecs[10] = '{1'b0, 1'b0, 2'b00, 18'h00, 16'h0000, 1'b1, 16'h0003};
        vecs[11] = '{1'b0, 1'b0, 2'b00, 18'h00, 16'h0000, 1'b0, 16'h0003};
        vecs[12] = '{1'b1, 1'b0, 2'b00, 18'h20, 16'h0000, 1'b0, 16'h0003};
        vecs[13] = '{1'b1, 1'b1, 2'b11, 18'h20, 16'h1234, 1'b0, 16'h0003};
        vecs[14] = '{1'b1, 1'b0, 2'b00, 18'h20, 16'h0000, 1'b1, 16'h0BAD};
        vecs[15] = '{1'b1, 1'b1, 2'b00, 18'h20, 16'hFFFF, 1'b0, 16'h0BAD};
        vecs[16] = '{1'b1, 1'b0, 2'b00, 18'h20, 16'h0000, 1'b1, 16'h1234};
        vecs[17] = '{1'b0, 1'b0, 2'b00, 18'h00, 16'h0000, 1'b0, 16'h1234};
        vecs[18] = '{1'b1, 1'b1, 2'b10, 18'h20, 16'h9977, 1'b1, 16'h1234};
        vecs[19] = '{1'b1, 1'b0, 2'b00, 18'h20, 16'h0000, 1'b0, 16'h1234};
        vecs[20] = '{1'b0, 1'b0, 2'b00, 18'h00, 16'h0000, 1'b0, 16'h1234};
        vecs[21] = '{1'b0, 1'b0, 2'b00, 18'h00, 16'h0000, 1'b1, 16'h9934};
        vecs[22] = '{1'b0, 1'b1, 2'b11, 18'h20, 16'h0000, 1'b0, 16'h9934};
        vecs[23] = '{1'b1, 1'b0, 2'b00, 18'h20, 16'h0000, 1'b0, 16'h9934};
        vecs[24] = '{1'b0, 1'b0, 2'b00, 18'h00, 16'h0000, 1'b0, 16'h9934};
        vecs[25] = '{1'b0, 1'b0, 2'b00, 18'h00, 16'h0000, 1'b1, 16'h9934};

        rst = 1'b1; dstart = 1'b0; dready = 1'b1;
        host(1'b0, 1'b0, 2'b00, 18'h0, 16'h0000);
        tick; tick;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", dbusy, 0);
        chk("rst_dvalid", dvalid, 0);
        chk("rst_dlast", dlast, 0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < NVEC; i++) begin
            host(vecs[i].ce, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
            tick;
            chk($sformatf("vec%0d_rvalid", i), rvalid, vecs[i].exp_v);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_d);
        end

        // Reset flushes an in-flight read but leaves memory intact
        host(1'b1, 1'b0, 2'b00, 18'h10, 16'h0000);
        tick;
        host(1'b0, 1'b0, 2'b00, 18'h0, 16'h0000);
        rst = 1'b1;
        tick;
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_rdata", rdata, 0);
        rst = 1'b0;
        tick;
        chk("flush_rvalid", rvalid, 0);
        host(1'b1, 1'b0, 2'b00, 18'h10, 16'h0000);
        tick;
        host(1'b0, 1'b0, 2'b00, 18'h0, 16'h0000);
        tick; tick;
        chk("mem_keep_rvalid", rvalid, 1);
        chk("mem_keep_rdata", rdata, 16'hA5FF);
        tick;

`ifdef SRAM_SYNC_MODEL_DUMP_EN
        for (int b = 0; b < NBEATS; b++) begin
            host(1'b1, 1'b1, 2'b11, beat_addr(b), 16'hD000 | 16'(b));
            tick;
        end
        host(1'b0, 1'b0, 2'b00, 18'h0, 16'h0000);
        tick; tick; tick; tick;

        dstart = 1'b1;
        collect(1'b0, 1'b0, NBEATS, n);
        chk("run_a_busy_fall", dbusy, 0);
        tick; tick; tick; tick;
        chk("level_no_restart", dbusy, 0);

        dstart = 1'b0; tick; dstart = 1'b1;
        collect(1'b1, 1'b1, NBEATS, n);
        chk("run_b_busy_fall", dbusy, 0);

        dstart = 1'b0; tick; dstart = 1'b1;
        collect(1'b0, 1'b0, 6, n);
        dready = 1'b1;
        rst = 1'b1;
        tick;
        chk("abort_busy", dbusy, 0);
        chk("abort_valid", dvalid, 0);
        chk("abort_data", ddata, 0);
        chk("abort_ch", dch, 0);
        chk("abort_last", dlast, 0);
        chk("abort_rvalid", rvalid, 0);
        rst = 1'b0;
        tick; tick; tick; tick;
        chk("start_held_over_reset", dbusy, 0);
        dstart = 1'b0; tick; dstart = 1'b1;
        collect(1'b0, 1'b0, NBEATS, n);
        chk("restart_busy_fall", dbusy, 0);
`else
        dstart = 1'b0; tick; dstart = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (i % 4 == 3) begin
                chk("tied_busy", dbusy, 0);
                chk("tied_valid", dvalid, 0);
                chk("tied_data", ddata, 0);
                chk("tied_ch", dch, 0);
                chk("tied_last", dlast, 0);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_sync_model.md
SRAM_SYNC_MODEL -- requirements
Module: sram_sync_model

Interface
REQ-001 SHALL have parameter AW, default 18, address width in words.
REQ-002 SHALL have parameter DW, default 16, data width; a multiple of 8, with NB = DW/8 byte lanes.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-004 SHALL have parameters SCR_W = 400, SCR_H = 96, SCR_N = 2: dump frame width, frame height, page count.
REQ-005 SHALL have port CLK, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port CE, input, 1 bit: host access request.
REQ-008 SHALL have port WE, input, 1 bit: 1 = write, 0 = read; qualified by CE.
REQ-009 SHALL have port BE, input, NB bits: byte-lane write enables.
REQ-010 SHALL have port ADDR, input, AW bits: host word address.
REQ-011 SHALL have port WDATA, input, DW bits: write data.
REQ-012 SHALL have port RDATA, output, DW bits: read data.
REQ-013 SHALL have port RVALID, output, 1 bit: RDATA valid, one-cycle pulse.
REQ-014 SHALL have port DUMP_START, input, 1 bit: rising-edge trigger for a screen dump.
REQ-015 SHALL have port DUMP_BUSY, output, 1 bit: dump in progress.
REQ-016 SHALL have ports DUMP_VALID (output, 1 bit), DUMP_READY (input, 1 bit) and DUMP_DATA (output, DW bits): dump stream.
REQ-017 SHALL have port DUMP_CH, output, 1 bit: 0 = left, 1 = right.
REQ-018 SHALL have port DUMP_LAST, output, 1 bit: marks the final beat of the dump.

Function
REQ-019 SHALL, on a write (CE=1, WE=1), update only the bytes whose BE bit is 1, at the clock edge.
REQ-020 SHALL, on a read (CE=1, WE=0), present MEM[ADDR] on RDATA together with RVALID=1 exactly RD_LAT cycles later; the pipeline is fully pipelined, accepting one read per cycle.
REQ-021 SHALL give read-first behaviour on a same-cycle read and write to the same address: the read returns the old data.
REQ-022 SHALL hold RDATA at its last valid value while RVALID=0.
REQ-023 SHALL form the dump address as {page, ch, y[6:0], x[8:0]}, zero-extended or truncated to AW.
REQ-024 SHALL run a dump FSM with states IDLE, ISSUE, WAIT, OUT and NEXT.
REQ-025 SHALL move IDLE->ISSUE on a DUMP_START rising edge; ISSUE->WAIT when the read is issued; WAIT->OUT after RD_LAT cycles; OUT->NEXT on DUMP_VALID & DUMP_READY; NEXT->ISSUE, or NEXT->IDLE after the final beat.
REQ-026 SHALL traverse the dump in this order, ch fastest: page 0..SCR_N-1, y 0..SCR_H-1, x 0..SCR_W-1, ch 0 then 1, giving 2*SCR_W*SCR_H*SCR_N beats in total.
REQ-027 SHALL wrap x at SCR_W-1 to 0 and increment y; y wraps at SCR_H-1 to 0 and increments page.
REQ-028 SHALL give the host port priority: when CE=1 in ISSUE, the dump read is deferred one cycle, with no host stall and no dump data loss.
REQ-029 SHALL hold DUMP_DATA and DUMP_CH stable while DUMP_VALID=1 and DUMP_READY=0.
REQ-030 SHALL assert DUMP_LAST only with DUMP_VALID, on the final beat.
REQ-031 SHALL ignore DUMP_START while DUMP_BUSY=1.
REQ-032 SHALL assert DUMP_BUSY in every state except IDLE.

Reset
REQ-033 SHALL, on RST=1 at a clock edge, set RDATA=0, RVALID=0, DUMP_BUSY=0, DUMP_VALID=0, DUMP_DATA=0, DUMP_CH=0, DUMP_LAST=0, FSM=IDLE, x=y=page=0, and flush the read pipeline.
REQ-034 SHALL leave memory contents unaffected by reset.
REQ-035 SHALL, on reset asserted mid-dump, abort the dump and discard any in-flight beat.
REQ-036 SHALL not start a dump when a DUMP_START level is held high across reset release; only a fresh rising edge starts one.

Configuration
REQ-037 SHALL compile the dump engine in only when macro SRAM_SYNC_MODEL_DUMP_EN is defined.
REQ-038 SHALL, without SRAM_SYNC_MODEL_DUMP_EN, keep all dump ports present, tie DUMP_BUSY, DUMP_VALID, DUMP_LAST, DUMP_CH and DUMP_DATA to 0, ignore DUMP_START, and keep the host port unchanged.

Verification
REQ-039 SHALL cover: write 0xA5C3 to addr 0x00010 with BE=11, then BE=01 write of 0xFFFF -> read returns 0xA5FF after RD_LAT cycles.
REQ-040 SHALL cover: RD_LAT=3, back-to-back reads of addr 1, 2, 3 -> RVALID high on 3 consecutive cycles starting 3 cycles after the first read, with data in order.
REQ-041 SHALL cover: same-cycle read and write of 0x1234 to an address holding 0x0BAD -> read returns 0x0BAD, and a later read returns 0x1234.
REQ-042 SHALL cover (macro on, SCR_W=4, SCR_H=2, SCR_N=2, DUMP_READY=1) -> 32 beats; beat 0 from addr 0x00000, beat 1 from 0x10000, DUMP_LAST on beat 31, then DUMP_BUSY falls.
REQ-043 SHALL cover: dump running with random DUMP_READY stalls and host CE bursts -> identical beat sequence to the unstalled run, and host reads correct.
REQ-044 SHALL cover: RST pulsed mid-dump -> all outputs 0 the next cycle, and a new DUMP_START edge restarts the dump from beat 0.
